// File: rtl/barcode_pkg.sv
// Shared types and helpers for the barcode frame decoder.
//   - state_e      : frame FSM states
//   - ERR_*        : err_code values presented on the result port
//   - SEG_LUT      : 7-segment patterns {g,f,e,d,c,b,a}, active-high, digits 0..9
//   - decode_2of5  : 2-of-5 symbol -> {valid, BCD digit}
//   - seg_encode   : BCD digit -> 7-segment pattern (blank for non-BCD input)
package barcode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2,
        ST_RESULT  = 2'd3
    } state_e;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_BAD_SYM   = 2'b01;
    localparam logic [1:0] ERR_CKSUM     = 2'b10;
    localparam logic [1:0] ERR_TMO_ABORT = 2'b11;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Bit weights are 1,2,4,7,0; exactly two bits set is a legal symbol and the
    // only pair summing to 11 (weights 4+7) stands for digit 0.
    function automatic logic [4:0] decode_2of5(input logic [4:0] code);
        logic [2:0] ones;
        logic [3:0] wsum;
        logic [4:0] res;
        ones = {2'b00, code[0]} + {2'b00, code[1]} + {2'b00, code[2]}
             + {2'b00, code[3]} + {2'b00, code[4]};
        wsum = {3'b000, code[0]} + {2'b00, code[1], 1'b0} + {1'b0, code[2], 2'b00}
             + (code[3] ? 4'd7 : 4'd0);
        if (ones == 3'd2) begin
            if (wsum == 4'd11) begin
                res = {1'b1, 4'd0};
            end else begin
                res = {1'b1, wsum};
            end
        end else begin
            res = 5'b0_0000;
        end
        return res;
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pat;
        if (digit < 4'd10) begin
            pat = SEG_LUT[digit];
        end else begin
            pat = 7'h00;
        end
        return pat;
    endfunction

endpackage

// File: rtl/barcode_frame_decoder_if.sv
// Symbol stream from the optical front-end sampler.
//   sym_valid : symbol present on sym_code (source -> decoder)
//   sym_code  : 5-bit 2-of-5 symbol       (source -> decoder)
//   sym_ready : decoder accepts a symbol   (decoder -> source)
// A transfer happens on a rising edge where sym_valid and sym_ready are both 1.
interface barcode_frame_decoder_if;
    logic       sym_valid;
    logic [4:0] sym_code;
    logic       sym_ready;

    modport master (output sym_valid, output sym_code, input sym_ready);
    modport slave  (input sym_valid, input sym_code, output sym_ready);
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scanner.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   digits_i   : BCD digits, digit 0 in the LSBs
//   seg_o      : registered {g,f,e,d,c,b,a} pattern of the selected digit
//   dig_sel_o  : one-hot digit enable, rotates left every REFRESH_DIV cycles
module seg_scan_mux
    import barcode_pkg::*;
#(
    parameter int NUM_DIGITS  = 5,
    parameter int REFRESH_DIV = 5000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_i,
    output logic [6:0]                seg_o,
    output logic [NUM_DIGITS-1:0]     dig_sel_o
);

    localparam int              RF_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_DIV - 1);

    logic [RF_W-1:0]       rf_cnt_q;
    logic [NUM_DIGITS-1:0] dig_sel_q;
    logic [6:0]            seg_q;
    logic [3:0]            cur_digit_d;

    // Pick the digit addressed by the one-hot select (AND-OR mux).
    always_comb begin
        cur_digit_d = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cur_digit_d = cur_digit_d | ({4{dig_sel_q[i]}} & digits_i[4*i +: 4]);
        end
    end

    // Refresh counter, select rotation and registered segment pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_cnt_q  <= '0;
            dig_sel_q <= NUM_DIGITS'(1);
            seg_q     <= 7'h00;
        end else begin
            if (rf_cnt_q == RF_LAST) begin
                rf_cnt_q  <= '0;
                dig_sel_q <= {dig_sel_q[NUM_DIGITS-2:0], dig_sel_q[NUM_DIGITS-1]};
            end else begin
                rf_cnt_q  <= rf_cnt_q + RF_W'(1);
            end
            seg_q <= seg_encode(cur_digit_d);
        end
    end

    assign seg_o     = seg_q;
    assign dig_sel_o = dig_sel_q;

endmodule

// File: rtl/barcode_frame_decoder.sv
// Barcode frame decoder: collects NUM_DIGITS 2-of-5 symbols into a frame,
// validates symbols (and optionally the check digit), holds the result and
// drives a scanned 7-segment display plus status LEDs.
// Optional feature macro: BARCODE_CHECKSUM_EN (defined -> last digit is a
// weighted mod-10 check digit and err_code 10 can occur).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   sym_if      : symbol stream (sym_valid/sym_code in, sym_ready out)
//   abort       : abandon the frame being collected/checked
//   result_ack  : release the held result, return to IDLE
//   frame_done  : one-cycle pulse on result entry
//   frame_ok    : held result is good
//   err_code    : 00 none, 01 bad symbol, 10 checksum, 11 timeout/abort
//   digits_out  : held BCD digits, first received in the LSBs
//   seg/dig_sel : scanned display drive
//   led_g/led_r : held result good / bad, cleared on result_ack
module barcode_frame_decoder
    import barcode_pkg::*;
#(
    parameter int NUM_DIGITS     = 5,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int REFRESH_DIV    = 5000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    barcode_frame_decoder_if.slave   sym_if,
    input  logic                     abort,
    input  logic                     result_ack,
    output logic                     frame_done,
    output logic                     frame_ok,
    output logic [1:0]               err_code,
    output logic [4*NUM_DIGITS-1:0]  digits_out,
    output logic [6:0]               seg,
    output logic [NUM_DIGITS-1:0]    dig_sel,
    output logic                     led_g,
    output logic                     led_r
);

    localparam int               DW       = 4 * NUM_DIGITS;
    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int               TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [TMO_W-1:0] tmo_q;
    logic             bad_q;
    logic [DW-1:0]    buf_q;
    logic [DW-1:0]    digits_q;
    logic             sym_ready_q;
    logic             frame_done_q;
    logic             frame_ok_q;
    logic [1:0]       err_q;
    logic             led_g_q;
    logic             led_r_q;

    logic [4:0]       dec_d;
    logic             xfer_d;
    logic             kill_d;
    logic [1:0]       verdict_d;

`ifdef BARCODE_CHECKSUM_EN
    logic [7:0]       acc_q;
    logic [7:0]       acc_add_d;
    logic [7:0]       acc_mod_d;
    logic [3:0]       req_check_d;
`endif

    // Symbol decode, handshake and the frame-kill (abort / idle timeout) condition.
    always_comb begin
        dec_d  = decode_2of5(sym_if.sym_code);
        xfer_d = sym_if.sym_valid & sym_ready_q;
        if (state_q == ST_COLLECT) begin
            // A transfer restarts the idle window, so it also defuses a timeout.
            kill_d = abort | (~xfer_d & (tmo_q == TMO_LAST));
        end else if (state_q == ST_CHECK) begin
            kill_d = abort;
        end else begin
            kill_d = 1'b0;
        end
    end

    // Frame verdict evaluated while in CHECK: bad symbol outranks checksum.
    always_comb begin
`ifdef BARCODE_CHECKSUM_EN
        // Even positions weigh 3, odd positions weigh 1; IDLE stores position 0.
        if ((state_q == ST_IDLE) || !idx_q[0]) begin
            acc_add_d = {4'd0, dec_d[3:0]} + {3'd0, dec_d[3:0], 1'b0};
        end else begin
            acc_add_d = {4'd0, dec_d[3:0]};
        end
        acc_mod_d = acc_q % 8'd10;
        if (acc_mod_d == 8'd0) begin
            req_check_d = 4'd0;
        end else begin
            req_check_d = 4'(8'd10 - acc_mod_d);
        end
`endif
        if (bad_q) begin
            verdict_d = ERR_BAD_SYM;
`ifdef BARCODE_CHECKSUM_EN
        end else if (buf_q[DW-1 -: 4] != req_check_d) begin
            verdict_d = ERR_CKSUM;
`endif
        end else begin
            verdict_d = ERR_NONE;
        end
    end

    // Frame FSM with all result/handshake outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            tmo_q        <= '0;
            bad_q        <= 1'b0;
            buf_q        <= '0;
            digits_q     <= '0;
            sym_ready_q  <= 1'b1;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            err_q        <= ERR_NONE;
            led_g_q      <= 1'b0;
            led_r_q      <= 1'b0;
`ifdef BARCODE_CHECKSUM_EN
            acc_q        <= 8'd0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            if (kill_d) begin
                // Abort or timeout: keep the previously held digits.
                state_q      <= ST_RESULT;
                sym_ready_q  <= 1'b0;
                frame_done_q <= 1'b1;
                frame_ok_q   <= 1'b0;
                err_q        <= ERR_TMO_ABORT;
                led_g_q      <= 1'b0;
                led_r_q      <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (xfer_d) begin
                            buf_q[3:0] <= dec_d[3:0];
                            bad_q      <= ~dec_d[4];
                            idx_q      <= IDX_W'(1);
                            tmo_q      <= '0;
                            state_q    <= ST_COLLECT;
`ifdef BARCODE_CHECKSUM_EN
                            acc_q      <= acc_add_d;
`endif
                        end
                    end
                    ST_COLLECT: begin
                        if (xfer_d) begin
                            buf_q[{idx_q, 2'b00} +: 4] <= dec_d[3:0];
                            bad_q <= bad_q | ~dec_d[4];
                            tmo_q <= '0;
                            if (idx_q == LAST_IDX) begin
                                state_q     <= ST_CHECK;
                                sym_ready_q <= 1'b0;
                            end else begin
                                idx_q <= idx_q + IDX_W'(1);
`ifdef BARCODE_CHECKSUM_EN
                                acc_q <= acc_q + acc_add_d;
`endif
                            end
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                    ST_CHECK: begin
                        state_q      <= ST_RESULT;
                        frame_done_q <= 1'b1;
                        frame_ok_q   <= (verdict_d == ERR_NONE);
                        err_q        <= verdict_d;
                        digits_q     <= buf_q;
                        led_g_q      <= (verdict_d == ERR_NONE);
                        led_r_q      <= (verdict_d != ERR_NONE);
                    end
                    ST_RESULT: begin
                        if (result_ack) begin
                            state_q     <= ST_IDLE;
                            sym_ready_q <= 1'b1;
                            led_g_q     <= 1'b0;
                            led_r_q     <= 1'b0;
                        end
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        sym_ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign sym_if.sym_ready = sym_ready_q;
    assign frame_done       = frame_done_q;
    assign frame_ok         = frame_ok_q;
    assign err_code         = err_q;
    assign digits_out       = digits_q;
    assign led_g            = led_g_q;
    assign led_r            = led_r_q;

    seg_scan_mux #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .digits_i  (digits_q),
        .seg_o     (seg),
        .dig_sel_o (dig_sel)
    );

endmodule
